mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-requester single-port memory arbiter (IDLE/ACCESS/RESP)
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int FIXED_PRIO    = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [7:0]  r0_addr,
  input  logic [23:0] r0_wdata,
  output logic        r0_ack,
  output logic [23:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [7:0]  r1_addr,
  input  logic [23:0] r1_wdata,
  output logic        r1_ack,
  output logic [23:0] r1_rdata,
  output logic [7:0]  mem_addr,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_cs,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES);

  state_t      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        grant_id_q,   grant_id_d;
  logic        last_grant_q, last_grant_d;
  logic        mem_cs_q,     mem_cs_d;
  logic        mem_en_q,     mem_en_d;
  logic [7:0]  mem_addr_q,   mem_addr_d;
  logic [23:0] mem_wdata_q,  mem_wdata_d;
  logic        r0_ack_q,     r0_ack_d;
  logic        r1_ack_q,     r1_ack_d;
  logic [23:0] r0_rdata_q,   r0_rdata_d;
  logic [23:0] r1_rdata_q,   r1_rdata_d;

  logic        winner;

  always_comb begin
    // With a tie, round-robin favours whoever was not granted last
    if (r0_req && r1_req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      winner = r1_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    mem_cs_d     = mem_cs_q;
    mem_en_d     = mem_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant_id_d   = winner;
          last_grant_d = winner;
          mem_en_d     = winner ? r1_we    : r0_we;
          mem_addr_d   = winner ? r1_addr  : r0_addr;
          mem_wdata_d  = winner ? r1_wdata : r0_wdata;
          mem_cs_d     = 1'b1;
          cnt_d        = CNT_LOAD;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // mem_en_q still carries the latched we at the final access cycle
          if (!mem_en_q) begin
            if (grant_id_q) r1_rdata_d = mem_rdata;
            else            r0_rdata_d = mem_rdata;
          end
          mem_cs_d = 1'b0;
          mem_en_d = 1'b0;
          r0_ack_d = ~grant_id_q;
          r1_ack_d = grant_id_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      mem_cs_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_wdata_q  <= 24'd0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_rdata_q   <= 24'd0;
      r1_rdata_q   <= 24'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      mem_cs_q     <= mem_cs_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed checks on three arbiter configurations
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int N = 3;

  logic        clock;
  logic        reset_n;
  logic        r0_req   [N];
  logic        r0_we    [N];
  logic [7:0]  r0_addr  [N];
  logic [23:0] r0_wdata [N];
  logic        r0_ack   [N];
  logic [23:0] r0_rdata [N];
  logic        r1_req   [N];
  logic        r1_we    [N];
  logic [7:0]  r1_addr  [N];
  logic [23:0] r1_wdata [N];
  logic        r1_ack   [N];
  logic [23:0] r1_rdata [N];
  logic [7:0]  mem_addr [N];
  logic [23:0] mem_wdata[N];
  logic [23:0] mem_rdata[N];
  logic        mem_en   [N];
  logic        mem_cs   [N];
  logic        busy     [N];
  logic        grant_id [N];

  int n_checks = 0;
  int n_errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instance 0: AC=1 round-robin, 1: AC=3 round-robin, 2: AC=1 fixed priority
  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    mem_arbiter #(
      .ACCESS_CYCLES((gi == 1) ? 3 : 1),
      .FIXED_PRIO   ((gi == 2) ? 1 : 0)
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .r0_req   (r0_req[gi]),
      .r0_we    (r0_we[gi]),
      .r0_addr  (r0_addr[gi]),
      .r0_wdata (r0_wdata[gi]),
      .r0_ack   (r0_ack[gi]),
      .r0_rdata (r0_rdata[gi]),
      .r1_req   (r1_req[gi]),
      .r1_we    (r1_we[gi]),
      .r1_addr  (r1_addr[gi]),
      .r1_wdata (r1_wdata[gi]),
      .r1_ack   (r1_ack[gi]),
      .r1_rdata (r1_rdata[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi]),
      .mem_en   (mem_en[gi]),
      .mem_cs   (mem_cs[gi]),
      .busy     (busy[gi]),
      .grant_id (grant_id[gi])
    );
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_mem
    logic [23:0] mem [256];
    always @(posedge clock) begin
      if (mem_cs[gi] && mem_en[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
    end
    assign mem_rdata[gi] = mem[mem_addr[gi]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int i, input string s);
    return $sformatf("d%0d_%s", i, s);
  endfunction

  function automatic logic ack_of(input int i, input bit who);
    return who ? r1_ack[i] : r0_ack[i];
  endfunction

  function automatic logic [23:0] rdata_of(input int i, input bit who);
    return who ? r1_rdata[i] : r0_rdata[i];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input bit who, input bit v, input bit we,
                         input logic [7:0] a, input logic [23:0] d);
    if (who) begin
      r1_req[i] = v; r1_we[i] = we; r1_addr[i] = a; r1_wdata[i] = d;
    end else begin
      r0_req[i] = v; r0_we[i] = we; r0_addr[i] = a; r0_wdata[i] = d;
    end
  endtask

  task automatic run_req(input int i, input bit who, input bit we, input logic [7:0] a,
                         input logic [23:0] d, input int ac,
                         input logic [23:0] exp_rd, input logic [23:0] exp_other);
    set_req(i, who, 1'b1, we, a, d);
    for (int c = 0; c < ac; c++) begin
      tick();
      check(tg(i, "cs"), mem_cs[i], 1);
      check(tg(i, "en"), mem_en[i], we);
      check(tg(i, "addr"), mem_addr[i], a);
      if (we) check(tg(i, "wdata"), mem_wdata[i], d);
      check(tg(i, "gid"), grant_id[i], who);
      check(tg(i, "early_ack"), {r0_ack[i], r1_ack[i]}, 0);
    end
    tick();
    check(tg(i, "ack"), ack_of(i, who), 1);
    check(tg(i, "other_ack"), ack_of(i, !who), 0);
    check(tg(i, "resp_cs"), mem_cs[i], 0);
    check(tg(i, "resp_en"), mem_en[i], 0);
    check(tg(i, "resp_busy"), busy[i], 1);
    check(tg(i, "rdata"), rdata_of(i, who), exp_rd);
    check(tg(i, "other_rdata"), rdata_of(i, !who), exp_other);
    set_req(i, who, 1'b0, we, a, d);
    tick();
    check(tg(i, "ack_off"), ack_of(i, who), 0);
    check(tg(i, "idle_busy"), busy[i], 0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
      set_req(i, 1'b1, 1'b0, 1'b0, 8'd0, 24'd0);
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check(tg(i, "rst_cs"), mem_cs[i], 0);
      check(tg(i, "rst_en"), mem_en[i], 0);
      check(tg(i, "rst_addr"), mem_addr[i], 0);
      check(tg(i, "rst_wdata"), mem_wdata[i], 0);
      check(tg(i, "rst_busy"), busy[i], 0);
      check(tg(i, "rst_gid"), grant_id[i], 0);
      check(tg(i, "rst_ack"), {r0_ack[i], r1_ack[i]}, 0);
      check(tg(i, "rst_rdata0"), r0_rdata[i], 0);
      check(tg(i, "rst_rdata1"), r1_rdata[i], 0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Single write then readback, one-cycle access
    run_req(0, 1'b0, 1'b1, 8'd4, 24'd96, 1, 24'd0, 24'd0);
    check("d0_mem4", g_mem[0].mem[4], 24'd96);
    run_req(0, 1'b1, 1'b0, 8'd4, 24'd0, 1, 24'd96, 24'd0);

    // Three-cycle access: write then read of addr 10
    run_req(1, 1'b0, 1'b1, 8'd10, 24'hABCDEF, 3, 24'd0, 24'd0);
    run_req(1, 1'b1, 1'b0, 8'd10, 24'd0, 3, 24'hABCDEF, 24'd0);

    // Request dropped and operands changed once the access is underway
    set_req(1, 1'b0, 1'b1, 1'b1, 8'd20, 24'd5);
    tick();
    check("d1_drop_cs", mem_cs[1], 1);
    check("d1_drop_addr0", mem_addr[1], 8'd20);
    set_req(1, 1'b0, 1'b0, 1'b0, 8'd99, 24'd7);
    tick();
    check("d1_drop_addr1", mem_addr[1], 8'd20);
    check("d1_drop_wdata", mem_wdata[1], 24'd5);
    check("d1_drop_en", mem_en[1], 1);
    tick();
    check("d1_drop_cs2", mem_cs[1], 1);
    check("d1_drop_addr2", mem_addr[1], 8'd20);
    tick();
    check("d1_drop_ack", r0_ack[1], 1);
    check("d1_drop_cs_off", mem_cs[1], 0);
    tick();
    check("d1_drop_ack_once", r0_ack[1], 0);
    check("d1_mem20", g_mem[1].mem[20], 24'd5);
    check("d1_mem99_untouched_rdata", r1_rdata[1], 24'hABCDEF);

    // Reset in the middle of a three-cycle read
    set_req(1, 1'b0, 1'b1, 1'b0, 8'd10, 24'd0);
    tick();
    tick();
    check("d1_pre_rst_cs", mem_cs[1], 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("d1_async_cs", mem_cs[1], 0);
    check("d1_async_busy", busy[1], 0);
    check("d1_async_rdata1", r1_rdata[1], 0);
    set_req(1, 1'b0, 1'b0, 1'b0, 8'd10, 24'd0);
    tick();
    tick();
    check("d1_rst_no_ack", {r0_ack[1], r1_ack[1]}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("d1_rel_no_ack", r0_ack[1], 0);
    check("d1_rel_busy", busy[1], 0);
    run_req(1, 1'b1, 1'b0, 8'd10, 24'd0, 3, 24'hABCDEF, 24'd0);

    // Continuous tie: round-robin on instance 0, fixed priority on instance 2
    set_req(0, 1'b0, 1'b1, 1'b0, 8'd4, 24'd0);
    set_req(0, 1'b1, 1'b1, 1'b0, 8'd4, 24'd0);
    set_req(2, 1'b0, 1'b1, 1'b1, 8'd8, 24'd1);
    set_req(2, 1'b1, 1'b1, 1'b1, 8'd9, 24'd2);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t % 3 == 1) begin
        check($sformatf("rr_cs_t%0d", t), mem_cs[0], 1);
        check($sformatf("rr_gid_t%0d", t), grant_id[0], ((t - 1) / 3) % 2);
        check($sformatf("fp_gid_t%0d", t), grant_id[2], 0);
      end else if (t % 3 == 2) begin
        check($sformatf("rr_ack0_t%0d", t), r0_ack[0], (((t - 2) / 3) % 2) == 0);
        check($sformatf("rr_ack1_t%0d", t), r1_ack[0], (((t - 2) / 3) % 2) == 1);
        check($sformatf("fp_acks_t%0d", t), {r0_ack[2], r1_ack[2]}, 2'b10);
      end else begin
        check($sformatf("rr_idle_t%0d", t), busy[0], 0);
        check($sformatf("fp_idle_t%0d", t), busy[2], 0);
      end
    end
    r0_req[0] = 1'b0;
    r0_req[2] = 1'b0;
    tick();
    check("rr_solo_gid", grant_id[0], 1);
    check("fp_solo_gid", grant_id[2], 1);
    check("fp_solo_cs", mem_cs[2], 1);
    r1_req[0] = 1'b0;
    r1_req[2] = 1'b0;
    tick();
    check("rr_solo_ack", r1_ack[0], 1);
    check("fp_solo_ack", r1_ack[2], 1);
    tick();
    check("fp_end_busy", busy[2], 0);
    check("fp_mem9", g_mem[2].mem[9], 24'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
